// File: rtl/bin_to_bcd_pkg.sv
// Shared widths, codes and types for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    localparam int BIN_W = 14;
    localparam int NDIG  = 4;
    localparam int SR_W  = NDIG * 4 + BIN_W;

    localparam logic [BIN_W-1:0] MAX_VAL    = 14'd9999;
    localparam logic [3:0]       BLANK_CODE = 4'hF;
    localparam logic [3:0]       LAST_ITER  = 4'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Digits are only updated on the final iteration, so the display never sees partial results.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output bcd_digit_t       d3,
    output bcd_digit_t       d2,
    output bcd_digit_t       d1,
    output bcd_digit_t       d0
);

    conv_state_t     state;
    conv_state_t     state_next;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_corr;
    logic [SR_W-1:0] sr_shift;
    logic [3:0]      iter;
    logic            ovf_pending;
    logic            load;
    logic            step;
    logic            last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (iter == LAST_ITER) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Each BCD nibble of the shift register is corrected before the shift.
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr[BIN_W + 4*g +: 4]),
            .dout (sr_corr[BIN_W + 4*g +: 4])
        );
    end

    assign sr_corr[BIN_W-1:0] = sr[BIN_W-1:0];
    assign sr_shift           = sr_corr << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr          <= '0;
            iter        <= '0;
            ovf_pending <= 1'b0;
            overflow    <= 1'b0;
            d3          <= '0;
            d2          <= '0;
            d1          <= '0;
            d0          <= '0;
        end else if (load) begin
            sr          <= {{(NDIG*4){1'b0}}, bin};
            iter        <= '0;
            ovf_pending <= (bin > MAX_VAL);
        end else if (step) begin
            sr   <= sr_shift;
            iter <= iter + 4'd1;
            if (last) begin
                overflow <= ovf_pending;
                d3 <= ovf_pending ? BLANK_CODE : sr_shift[SR_W-1  -: 4];
                d2 <= ovf_pending ? BLANK_CODE : sr_shift[SR_W-5  -: 4];
                d1 <= ovf_pending ? BLANK_CODE : sr_shift[SR_W-9  -: 4];
                d0 <= ovf_pending ? BLANK_CODE : sr_shift[SR_W-13 -: 4];
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized scoreboard bench for bin_to_bcd_seq: arithmetic reference model plus a
// per-cycle monitor that checks handshake timing and that digits only change on done.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [15:0] digits;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [13:0] bin;
    logic        start;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  d3;
    logic [3:0]  d2;
    logic [3:0]  d1;
    logic [3:0]  d0;

    int   total = 0;
    int   bad   = 0;
    int   edgeCount = 0;
    int   acc    = -100;
    int   freeAt = 0;
    bit   checkEn = 0;
    exp_t sb[$];
    exp_t curExp;

    bin_to_bcd_seq dut (
        .clk      (clk),
        .reset    (reset),
        .bin      (bin),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .d3       (d3),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount++;

    // Decimal digits from plain integer division; out-of-range values blank the display.
    function automatic exp_t refConvert(input int v);
        exp_t e;
        if (v > 9999) begin
            e.digits = 16'hFFFF;
            e.ovf    = 1'b1;
        end else begin
            e.digits = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf    = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    task automatic clearModel();
        sb.delete();
        curExp.digits = 16'h0000;
        curExp.ovf    = 1'b0;
        acc    = -100;
        freeAt = 0;
    endtask

    // Drives start for the given number of edges; a start is accepted when the
    // converter is free, with a 16-cycle period between acceptances.
    task automatic applyStimulus(input int value, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bin   = 14'(value);
            start = 1'b1;
            if (edgeCount + 1 >= freeAt) begin
                sb.push_back(refConvert(value));
                acc    = edgeCount + 1;
                freeAt = acc + 16;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        bin   = 14'($urandom_range(0, 16383));
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (edgeCount + 1 < freeAt && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) checkOutput("wait_idle_timeout", guard, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        reset = 1'b1;
        @(posedge clk);
        #1;
        clearModel();
        for (int i = 1; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", int'(busy), int'(edgeCount >= acc && edgeCount <= acc + 13));
            checkOutput("done", int'(done), int'(edgeCount == acc + 14));
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("scoreboard_underrun", 0, 1);
                end else begin
                    curExp = sb.pop_front();
                end
            end
            checkOutput("digits", int'({d3, d2, d1, d0}), int'(curExp.digits));
            checkOutput("overflow", int'(overflow), int'(curExp.ovf));
        end
    end

    initial begin
        int v;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        clearModel();
        checkEn = 1;
        reset   = 1'b0;
        repeat (50) @(posedge clk);
        #1;

        applyStimulus(1234, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(777, 1);
        waitIdle();

        applyStimulus(9999, 1);
        waitIdle();
        applyStimulus(0, 1);
        waitIdle();
        applyStimulus(10000, 1);
        waitIdle();
        applyStimulus(16383, 1);
        waitIdle();
        applyStimulus(42, 1);
        waitIdle();

        applyStimulus(56, 40);
        waitIdle();

        applyStimulus(8888, 1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        applyReset(1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(5678, 1);
        waitIdle();

        for (int i = 0; i < 30; i++) begin
            v = (i % 5 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(v, 1);
            waitIdle();
        end

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
